// File: rtl/pin_sampler.sv
// pin_sampler: front end of the sample-collection path.
//
// Synchronises the external pins, keeps a sticky edge flag per channel,
// runs a prescaled 14-bit timestamp and presents a registered sample word
// {level, edge, timestamp} for the channel on channel_select. Configured
// and observed over the EBI bus.
//
// Ports:
//   clk, rst        system clock, synchronous active-high reset
//   pins            asynchronous external pin levels
//   channel_select  channel whose sample is presented
//   output_sample   one-cycle strobe: selected channel consumed, clear its flag
//   addr            EBI address; unit matches when addr[18:8] == POSITION
//   ebi_data_in     EBI write data
//   ebi_data_out    EBI read data (registered, holds between reads)
//   cs, re, wr      EBI chip select, read, write strobes
//   sample_data     {level, edge_flag, timestamp[13:0]} for selected channel
//
// Register map (addr[7:0]):
//   0 CONTROL   : bit0 enable (r/w), bit1 clear timestamp+prescaler (write only)
//   1 PRESCALE  : 16-bit prescale value (r/w)
//   2 TIMESTAMP : {2'b0, timestamp} (read only)
//   3 EDGES     : edge flags, zero-extended (read only)
module pin_sampler #(
    parameter int POSITION     = 243,
    parameter int NUM_CHANNELS = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_CHANNELS-1:0] pins,
    input  logic [7:0]              channel_select,
    input  logic                    output_sample,
    input  logic [18:0]             addr,
    input  logic [15:0]             ebi_data_in,
    output logic [15:0]             ebi_data_out,
    input  logic                    cs,
    input  logic                    re,
    input  logic                    wr,
    output logic [15:0]             sample_data
);

    localparam logic [10:0] UNIT = 11'(POSITION);

    logic [NUM_CHANNELS-1:0] s1_q, s2_q, s3_q;
    logic [NUM_CHANNELS-1:0] edge_now;
    logic [NUM_CHANNELS-1:0] clr_hit;
    logic [NUM_CHANNELS-1:0] edge_flag_q, edge_flag_d;
    logic                    enable_q, enable_d;
    logic [15:0]             prescale_q, prescale_d;
    logic [15:0]             pcnt_q, pcnt_d;
    logic [13:0]             timestamp_q, timestamp_d;
    logic [15:0]             sample_q, sample_d;
    logic [15:0]             rdata_q, rdata_d;
    logic [15:0]             flags_ext;
    logic                    sel_level, sel_flag, sel_valid;
    logic                    unit_hit, wr_hit, rd_hit;

    assign unit_hit = cs && (addr[18:8] == UNIT);
    assign wr_hit   = unit_hit && wr;
    assign rd_hit   = unit_hit && re;

    assign edge_now = s2_q ^ s3_q;

    // A fresh edge in the same cycle as the consume strobe must not be lost,
    // so the set term dominates the clear term.
    generate
        for (genvar gi = 0; gi < NUM_CHANNELS; gi++) begin : g_flag
            assign clr_hit[gi]     = output_sample && (channel_select == 8'(gi));
            assign edge_flag_d[gi] = edge_now[gi] | (edge_flag_q[gi] & ~clr_hit[gi]);
        end
    endgenerate

    // Prescaler / timestamp and configuration writes. The clear bit is applied
    // after the tick logic so that it overrides a same-cycle increment.
    always_comb begin
        enable_d    = enable_q;
        prescale_d  = prescale_q;
        pcnt_d      = pcnt_q;
        timestamp_d = timestamp_q;
        if (enable_q) begin
            if (pcnt_q == prescale_q) begin
                pcnt_d      = 16'd0;
                timestamp_d = timestamp_q + 14'd1;
            end else begin
                // Plain 16-bit wrap: a PRESCALE written below pcnt is reached
                // only after the counter rolls over.
                pcnt_d = pcnt_q + 16'd1;
            end
        end
        if (wr_hit) begin
            case (addr[7:0])
                8'd0: begin
                    enable_d = ebi_data_in[0];
                    if (ebi_data_in[1]) begin
                        pcnt_d      = 16'd0;
                        timestamp_d = 14'd0;
                    end
                end
                8'd1:    prescale_d = ebi_data_in;
                default: ;
            endcase
        end
    end

    // Channel mux; out-of-range selections yield zero level/flag.
    always_comb begin
        sel_level = 1'b0;
        sel_flag  = 1'b0;
        sel_valid = 1'b0;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            if (channel_select == 8'(i)) begin
                sel_level = s2_q[i];
                sel_flag  = edge_flag_q[i];
                sel_valid = 1'b1;
            end
        end
        sample_d = sel_valid ? {sel_level, sel_flag, timestamp_q}
                             : {2'b00, timestamp_q};
    end

    always_comb begin
        flags_ext                   = '0;
        flags_ext[NUM_CHANNELS-1:0] = edge_flag_q;
    end

    // Reads see pre-edge register values, so a same-cycle write returns old data.
    always_comb begin
        rdata_d = rdata_q;
        if (rd_hit) begin
            case (addr[7:0])
                8'd0:    rdata_d = {15'd0, enable_q};
                8'd1:    rdata_d = prescale_q;
                8'd2:    rdata_d = {2'b00, timestamp_q};
                8'd3:    rdata_d = flags_ext;
                default: rdata_d = 16'h0000;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q        <= '0;
            s2_q        <= '0;
            s3_q        <= '0;
            edge_flag_q <= '0;
            enable_q    <= 1'b0;
            prescale_q  <= 16'd0;
            pcnt_q      <= 16'd0;
            timestamp_q <= 14'd0;
            sample_q    <= 16'h0000;
            rdata_q     <= 16'h0000;
        end else begin
            s1_q        <= pins;
            s2_q        <= s1_q;
            s3_q        <= s2_q;
            edge_flag_q <= edge_flag_d;
            enable_q    <= enable_d;
            prescale_q  <= prescale_d;
            pcnt_q      <= pcnt_d;
            timestamp_q <= timestamp_d;
            sample_q    <= sample_d;
            rdata_q     <= rdata_d;
        end
    end

    assign sample_data  = sample_q;
    assign ebi_data_out = rdata_q;

endmodule

// File: doc/pin_sampler.md
# pin_sampler

Front end of the sample-collection path. It synchronises the external pin inputs and keeps a sticky edge flag per channel. It runs a prescaled 14-bit timestamp and presents a registered `sample_data` word for the channel currently on `channel_select`. The sample-storage block drives `channel_select`/`output_sample` and stores `sample_data`; this block is configured over the EBI bus.

## Interface
- `POSITION`, 243, EBI unit position; block responds when `cs & addr[18:8]==POSITION`.
- `NUM_CHANNELS`, 16, number of pins sampled (1..16).
- `clk`  in  1  system clock.
- `rst`  in  1  reset: synchronous, active-high.
- `pins`  in  NUM_CHANNELS  asynchronous external pin levels.
- `channel_select`  in  8  channel whose sample is presented.
- `output_sample`  in  1  one-cycle strobe: selected channel consumed, clear its edge flag.
- `addr`  in  19  EBI address.
- `ebi_data_in`  in  16  EBI write data.
- `ebi_data_out`  out  16  EBI read data (registered).
- `cs`, `re`, `wr`  in  1 each  EBI chip select, read, write.
- `sample_data`  out  16  {level, edge, timestamp[13:0]} for the selected channel.

## Operation
- **Synchroniser:** each pin passes through 2 flops (`s1`, `s2`); `level[i] = s2[i]`. A third flop `s3` supports edge detection: `edge_now[i] = s2[i]^s3[i]`.
- **Edge flags:** `edge_flag[i]` is set on `edge_now[i]`. It is cleared when `output_sample` is high, `channel_select==i` and `edge_now[i]==0`. If `edge_now[i]` is high in that same cycle, the set wins and the flag stays 1.
- **Prescaler:** 16-bit `pcnt`. When `enable`:
  - if `pcnt==PRESCALE`: `pcnt<=0` and `timestamp<=timestamp+1` (14-bit, wraps 0x3FFF→0);
  - otherwise `pcnt<=pcnt+1`.
  - `PRESCALE==0` means a tick every cycle.
  - When `!enable`, both `pcnt` and `timestamp` hold. Edge detection continues regardless of `enable`.
- **sample_data:** updated every cycle.
  - `channel_select<NUM_CHANNELS`: `sample_data <= {level[ch], edge_flag[ch], timestamp}`, using pre-edge register values.
  - Otherwise: `sample_data <= {2'b00, timestamp}`. `output_sample` with an out-of-range channel has no effect.
- **EBI register writes** (`cs & wr & unit match`), by `addr[7:0]`:
  - 0 CONTROL: bit0 = `enable`. Bit1 = clear: zeroes `timestamp` and `pcnt` this cycle and is not stored. Clear overrides a same-cycle tick.
  - 1 PRESCALE: full 16 bits. `pcnt` is not reset; if the new `PRESCALE` is below `pcnt`, the counter runs up to 0xFFFF, wraps to 0, then matches.
  - Writes to other addresses are ignored.
- **EBI register reads** (`cs & re & unit match`), `ebi_data_out` registered:
  - 0: {15'b0, enable}
  - 1: PRESCALE
  - 2: {2'b0, timestamp}
  - 3: `edge_flag` zero-extended to 16 bits
  - other addresses: 0x0000
  - `ebi_data_out` holds its value when not reading.

## Timing
- **Reset values:** `s1/s2/s3=0`, `edge_flag=0`, `enable=0`, `PRESCALE=0`, `pcnt=0`, `timestamp=0`, `sample_data=0x0000`, `ebi_data_out=0x0000`. A reset mid-count or mid-read discards all state.
- **Pin to level:** a pin change appears in `level` 2 cycles later. `edge_flag` is set 3 cycles after the pin change (first edge at `s2`/`s3`), and the change shows in `sample_data` 1 cycle after that.
- **Channel select:** `channel_select` change → `sample_data` reflects the new channel 1 cycle later.
- **Clear strobe:** `output_sample` clears the flag at that edge; the next `sample_data` shows `edge=0` one cycle after the flag clears.
- **Timestamp:** with `enable=1` and prescale P, `timestamp` increments every P+1 cycles. The first increment comes P+1 cycles after `enable` is written, given `pcnt=0`.
- **EBI:** write takes effect at the clock edge where `wr` is high. Read data appears on `ebi_data_out` 1 cycle after `re`. A read and write to the same register in one cycle returns the old value.

## Test plan
1. Reset, then read addr 0,1,2,3 → 0x0000 each; `sample_data==0x0000`.
2. Write CONTROL=1, PRESCALE=3; wait 40 cycles → read TIMESTAMP = 10 (±1 for the read cycle); write CONTROL=2 → timestamp 0 and `enable` off (reads 0); write CONTROL=3 → timestamp 0 and counting resumes.
3. Toggle `pins[5]` 0→1 with `channel_select=5` → `sample_data[15:14]=2'b11` within 4 cycles; pulse `output_sample` → bit14=0 two cycles later, bit15 stays 1.
4. Pin edge on channel 5 in the same cycle as the `output_sample` clear → `edge_flag[5]` remains 1 (read addr 3 = 0x0020).
5. PRESCALE=0, enable → timestamp 0x3FFF wraps to 0x0000 on the next cycle; `channel_select=200` → `sample_data[15:14]=0` and `output_sample` leaves all flags unchanged.
